// File: rtl/trace_cmd_pkg.sv
// Shared definitions for the trace-controller command link: opcodes, one-hot
// header words and the initiator FSM state encoding (decoder uses the same headers).
package trace_cmd_pkg;

  localparam int TRACE_ADDR_W = 13;
  localparam int TRACE_DATA_W = 16;

  typedef enum logic [2:0] {
    OP_WR_ADDR = 3'd0,
    OP_RD_ADDR = 3'd1,
    OP_RD_CMD  = 3'd2,
    OP_WR_CMD  = 3'd3,
    OP_INIT    = 3'd4
  } cmd_op_e;

  localparam logic [15:0] HDR_WR_ADDR = 16'h0001;
  localparam logic [15:0] HDR_RD_ADDR = 16'h0002;
  localparam logic [15:0] HDR_RD_CMD  = 16'h0004;
  localparam logic [15:0] HDR_WR_CMD  = 16'h0008;
  localparam logic [15:0] HDR_INIT    = 16'h8000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_ADDR   = 3'd2,
    S_RDHOLD = 3'd3,
    S_WDATA  = 3'd4,
    S_GAP    = 3'd5
  } trace_state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

  function automatic logic [15:0] hdr_word(input cmd_op_e op);
    case (op)
      OP_WR_ADDR: return HDR_WR_ADDR;
      OP_RD_ADDR: return HDR_RD_ADDR;
      OP_RD_CMD:  return HDR_RD_CMD;
      OP_WR_CMD:  return HDR_WR_CMD;
      OP_INIT:    return HDR_INIT;
      default:    return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/a_logic_trace_cmd_gen.sv
// Host-side initiator: serialises one command at a time onto the fp1 bus as
// one-hot header, optional payload, then a ctrl-low gap.
module a_logic_trace_cmd_gen
  import trace_cmd_pkg::*;
#(
  parameter int ADDR_W     = TRACE_ADDR_W,
  parameter int DATA_W     = TRACE_DATA_W,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [ADDR_W-1:0] cmd_len_i,
  input  logic [3:0]        cmd_fpga_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_data_valid_i,
  output logic              wr_data_ready_o,
  output logic [DATA_W-1:0] fp1_data_o,
  output logic              fp1_dv_o,
  output logic              ctrl_trce_o,
  output logic              carte_o,
  output logic [3:0]        fpga_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int GAP_W = 4;

  trace_state_e      state_reg;
  cmd_op_e           op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic [GAP_W-1:0]  gap_reg;

  logic              cmd_ready_reg;
  logic              wr_ready_reg;
  logic [DATA_W-1:0] data_reg;
  logic              dv_reg;
  logic              ctrl_reg;
  logic              carte_reg;
  logic [3:0]        fpga_reg;
  logic              done_reg;
  logic              err_reg;

  logic accept;
  logic word_take;
  logic go_gap;

  assign accept    = cmd_valid_i && cmd_ready_reg;
  assign word_take = wr_data_valid_i && wr_ready_reg;

  // Frame body finished this cycle: next cycle is the first gap cycle.
  always_comb begin
    go_gap = 1'b0;
    case (state_reg)
      S_HDR:    go_gap = (op_reg == OP_INIT) ||
                         (((op_reg == OP_RD_CMD) || (op_reg == OP_WR_CMD)) && (cnt_reg == '0));
      S_ADDR:   go_gap = 1'b1;
      S_RDHOLD: go_gap = (cnt_reg <= ADDR_W'(1));
      S_WDATA:  go_gap = (cnt_reg == '0);
      default:  go_gap = 1'b0;
    endcase
  end

  always_ff @(posedge clk_ref or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      op_reg        <= OP_WR_ADDR;
      addr_reg      <= '0;
      cnt_reg       <= '0;
      gap_reg       <= '0;
      cmd_ready_reg <= 1'b0;
      wr_ready_reg  <= 1'b0;
      data_reg      <= '0;
      dv_reg        <= 1'b0;
      ctrl_reg      <= 1'b0;
      carte_reg     <= 1'b0;
      fpga_reg      <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (accept) begin
        cmd_ready_reg <= 1'b0;
        wr_ready_reg  <= 1'b0;
        op_reg        <= cmd_op_e'(cmd_op_i);
        addr_reg      <= cmd_addr_i;
        cnt_reg       <= cmd_len_i;
        gap_reg       <= '0;
        if (is_legal_op(cmd_op_i)) begin
          state_reg <= S_HDR;
          data_reg  <= DATA_W'(hdr_word(cmd_op_e'(cmd_op_i)));
          dv_reg    <= 1'b1;
          ctrl_reg  <= 1'b1;
          carte_reg <= 1'b1;
          fpga_reg  <= cmd_fpga_i;
        end else begin
          // Illegal opcode is swallowed: no bus activity, just the error pulse.
          state_reg <= S_IDLE;
          err_reg   <= 1'b1;
          data_reg  <= '0;
          dv_reg    <= 1'b0;
          ctrl_reg  <= 1'b0;
          carte_reg <= 1'b0;
        end
      end else if (go_gap) begin
        state_reg     <= S_GAP;
        data_reg      <= '0;
        dv_reg        <= 1'b0;
        ctrl_reg      <= 1'b0;
        carte_reg     <= 1'b0;
        wr_ready_reg  <= 1'b0;
        gap_reg       <= GAP_W'(GAP_CYCLES - 1);
        done_reg      <= (GAP_CYCLES == 1);
        cmd_ready_reg <= (GAP_CYCLES == 1);
      end else begin
        case (state_reg)
          S_IDLE: cmd_ready_reg <= 1'b1;
          S_HDR: begin
            case (op_reg)
              OP_WR_ADDR, OP_RD_ADDR: begin
                state_reg <= S_ADDR;
                data_reg  <= DATA_W'(addr_reg);
                dv_reg    <= 1'b1;
              end
              OP_RD_CMD: begin
                state_reg <= S_RDHOLD;
                data_reg  <= '0;
                dv_reg    <= 1'b0;
              end
              OP_WR_CMD: begin
                state_reg    <= S_WDATA;
                data_reg     <= '0;
                dv_reg       <= 1'b0;
                wr_ready_reg <= 1'b1;
              end
              default: state_reg <= S_IDLE;
            endcase
          end
          S_RDHOLD: cnt_reg <= cnt_reg - ADDR_W'(1);
          S_WDATA: begin
            if (word_take) begin
              data_reg     <= wr_data_i;
              dv_reg       <= 1'b1;
              cnt_reg      <= cnt_reg - ADDR_W'(1);
              wr_ready_reg <= (cnt_reg != ADDR_W'(1));
            end else begin
              data_reg <= '0;
              dv_reg   <= 1'b0;
            end
          end
          S_GAP: begin
            // Ready rises with done so a queued command lands right after the gap.
            if (gap_reg == '0) begin
              state_reg <= S_IDLE;
            end else begin
              gap_reg <= gap_reg - GAP_W'(1);
              if (gap_reg == GAP_W'(1)) begin
                done_reg      <= 1'b1;
                cmd_ready_reg <= 1'b1;
              end
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready_o     = cmd_ready_reg;
  assign wr_data_ready_o = wr_ready_reg;
  assign fp1_data_o      = data_reg;
  assign fp1_dv_o        = dv_reg;
  assign ctrl_trce_o     = ctrl_reg;
  assign carte_o         = carte_reg;
  assign fpga_o          = fpga_reg;
  assign done_o          = done_reg;
  assign err_o           = err_reg;

endmodule

// File: tb/tb_a_logic_trace_cmd_gen.sv
// Bench for the trace command generator: vector table, random frames against a
// frame-level model, and hand sequences for back-to-back, illegal op and reset.
module tb_a_logic_trace_cmd_gen;

  localparam int GAP = 2;

  logic        clk_ref = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [2:0]  cmd_op_i = '0;
  logic [12:0] cmd_addr_i = '0;
  logic [12:0] cmd_len_i = '0;
  logic [3:0]  cmd_fpga_i = '0;
  logic [15:0] wr_data_i = '0;
  logic        wr_data_valid_i = 1'b0;
  logic        wr_data_ready_o;
  logic [15:0] fp1_data_o;
  logic        fp1_dv_o;
  logic        ctrl_trce_o;
  logic        carte_o;
  logic [3:0]  fpga_o;
  logic        done_o;
  logic        err_o;

  int total = 0;
  int bad = 0;

  a_logic_trace_cmd_gen #(.ADDR_W(13), .DATA_W(16), .GAP_CYCLES(GAP)) dut (
    .clk_ref(clk_ref), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .cmd_fpga_i(cmd_fpga_i), .wr_data_i(wr_data_i),
    .wr_data_valid_i(wr_data_valid_i), .wr_data_ready_o(wr_data_ready_o),
    .fp1_data_o(fp1_data_o), .fp1_dv_o(fp1_dv_o), .ctrl_trce_o(ctrl_trce_o),
    .carte_o(carte_o), .fpga_o(fpga_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_ref = ~clk_ref;

  typedef struct {
    logic [2:0]  op;
    logic [12:0] addr;
    logic [12:0] len;
    logic [3:0]  fpga;
    logic [15:0] stall;
    logic [15:0] hdr;
    int          hold;
    int          nwords;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  // Frame-level model straight from the opcode rules.
  function automatic logic [15:0] model_hdr(input logic [2:0] op);
    logic [15:0] one = 16'h0001;
    return (op == 3'd4) ? 16'h8000 : (one << op);
  endfunction

  task automatic wait_ready(input string name);
    int g = 0;
    while (!cmd_ready_o && g < 50) begin
      tick();
      g++;
    end
    if (!cmd_ready_o) check({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while (!done_o && g < 60) begin
      tick();
      g++;
    end
    check({name, "_done"}, done_o, 1);
  endtask

  // Issue one command, drive payload per the stall mask, observe the frame.
  task automatic do_frame(input string name, input vec_t v, input bit rnd_words);
    logic [15:0] wq[$];
    logic [15:0] expq[$];
    logic [15:0] obs[$];
    int wpos = 0, sidx = 0, hold = 0, low = 0, cyc = 0;
    bit got_done = 0, reopen = 0, gapbad = 0, cartebad = 0, errbad = 0, take;
    for (int i = 0; i < int'(v.len) && v.op == 3'd3; i++)
      wq.push_back(rnd_words ? 16'($urandom) : 16'hA001 + 16'(i));
    if (v.op < 3'd2) expq.push_back({3'b000, v.addr});
    foreach (wq[i]) expq.push_back(wq[i]);

    wait_ready(name);
    cmd_op_i = v.op; cmd_addr_i = v.addr; cmd_len_i = v.len; cmd_fpga_i = v.fpga;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    check({name, "_hdr"}, {fp1_data_o, fp1_dv_o, ctrl_trce_o, carte_o}, {v.hdr, 3'b111});
    while (!got_done && cyc < 200) begin
      if (cyc > 0) begin
        if (fp1_dv_o) obs.push_back(fp1_data_o);
        if (ctrl_trce_o && !fp1_dv_o) hold++;
        if (!ctrl_trce_o) begin
          low++;
          if (fp1_dv_o || fp1_data_o != 16'h0) gapbad = 1;
        end
        if (ctrl_trce_o && low > 0) reopen = 1;
        if (carte_o != ctrl_trce_o) cartebad = 1;
        if (err_o) errbad = 1;
        if (done_o) got_done = 1;
      end
      take = 0;
      wr_data_valid_i = 1'b0;
      if (!got_done && wr_data_ready_o && wpos < wq.size()) begin
        wr_data_valid_i = !v.stall[sidx % 16];
        wr_data_i = wq[wpos];
        take = wr_data_valid_i;
        sidx++;
      end else if (!got_done && wr_data_ready_o) begin
        sidx++;
      end
      if (!got_done) begin
        @(posedge clk_ref);
        if (take) wpos++;
        #1;
        cyc++;
      end
    end
    wr_data_valid_i = 1'b0;
    check({name, "_done_seen"}, got_done, 1);
    check({name, "_gap_len"}, low, GAP);
    check({name, "_nwords"}, obs.size(), v.nwords);
    for (int i = 0; i < obs.size() && i < expq.size(); i++)
      check({name, "_word"}, obs[i], expq[i]);
    if (v.hold >= 0) check({name, "_hold"}, hold, v.hold);
    check({name, "_envelope"}, {reopen, gapbad, cartebad, errbad}, 4'b0);
    check({name, "_fpga"}, fpga_o, v.fpga);
    $display("frame %s op=%0d addr=%h len=%0d words=%0d low=%0d", name, v.op, v.addr, v.len, obs.size(), low);
  endtask

  initial begin
    int g;
    int low;
    bit found;
    vec_t r;

    tbl[0] = '{3'd0, 13'h1ABC, 13'd0, 4'd3,  16'h0000, 16'h0001, 0,  1};
    tbl[1] = '{3'd1, 13'h1FFF, 13'd0, 4'd5,  16'h0000, 16'h0002, 0,  1};
    tbl[2] = '{3'd2, 13'h0000, 13'd5, 4'd1,  16'h0000, 16'h0004, 5,  0};
    tbl[3] = '{3'd3, 13'h0000, 13'd4, 4'd7,  16'h000E, 16'h0008, -1, 4};
    tbl[4] = '{3'd2, 13'h0000, 13'd0, 4'd2,  16'h0000, 16'h0004, 0,  0};
    tbl[5] = '{3'd3, 13'h0000, 13'd0, 4'd9,  16'h0000, 16'h0008, 0,  0};
    tbl[6] = '{3'd4, 13'h0000, 13'd0, 4'd15, 16'h0000, 16'h8000, 0,  0};
    tbl[7] = '{3'd3, 13'h0000, 13'd1, 4'd4,  16'h0000, 16'h0008, -1, 1};

    // Reset state
    repeat (3) tick();
    check("reset_outputs", {cmd_ready_o, wr_data_ready_o, fp1_data_o, fp1_dv_o, ctrl_trce_o,
                            carte_o, fpga_o, done_o, err_o}, 32'h0);
    rst = 1'b1;
    tick();
    check("ready_after_reset", cmd_ready_o, 1);
    $display("reset released ready=%0b", cmd_ready_o);

    foreach (tbl[i]) do_frame($sformatf("vec%0d", i), tbl[i], 0);

    for (int i = 0; i < 16; i++) begin
      r.op = 3'($urandom_range(0, 4));
      r.addr = 13'($urandom);
      r.len = 13'($urandom_range(0, 6));
      r.fpga = 4'($urandom);
      r.stall = 16'($urandom) & 16'h5555;
      r.hdr = model_hdr(r.op);
      r.hold = (r.op == 3'd2) ? int'(r.len) : ((r.op == 3'd3 && r.len != 0) ? -1 : 0);
      r.nwords = (r.op < 3'd2) ? 1 : ((r.op == 3'd3) ? int'(r.len) : 0);
      do_frame($sformatf("rnd%0d", i), r, 1);
    end

    // INIT followed immediately by WR_ADDR with valid held
    wait_ready("b2b");
    cmd_op_i = 3'd4; cmd_fpga_i = 4'd6; cmd_valid_i = 1'b1;
    tick();
    check("b2b_init_hdr", {fp1_data_o, ctrl_trce_o}, {16'h8000, 1'b1});
    check("b2b_ready_low", cmd_ready_o, 0);
    cmd_op_i = 3'd0; cmd_addr_i = 13'h0555;
    low = 0; found = 0; g = 0;
    while (!found && g < 20) begin
      tick();
      g++;
      if (ctrl_trce_o && fp1_data_o == 16'h0001) found = 1;
      else if (!ctrl_trce_o) low++;
      else if (ctrl_trce_o && fp1_data_o != 16'h8000) low = 99;
    end
    cmd_valid_i = 1'b0;
    check("b2b_second_hdr", found, 1);
    check("b2b_low_cycles", low, GAP);
    tick();
    check("b2b_addr_word", {fp1_data_o, fp1_dv_o}, {16'h0555, 1'b1});
    wait_done("b2b");
    $display("b2b init->wr_addr low=%0d", low);

    // Illegal opcode
    tick();
    wait_ready("illegal");
    cmd_op_i = 3'd6; cmd_valid_i = 1'b1;
    tick();
    check("illegal_err", {err_o, cmd_ready_o}, 2'b10);
    check("illegal_bus", {fp1_data_o, fp1_dv_o, ctrl_trce_o, carte_o}, 19'h0);
    cmd_op_i = 3'd0; cmd_addr_i = 13'h0123;
    tick();
    check("illegal_err_once", {err_o, cmd_ready_o, ctrl_trce_o}, 3'b010);
    tick();
    cmd_valid_i = 1'b0;
    check("illegal_next_hdr", {fp1_data_o, ctrl_trce_o}, {16'h0001, 1'b1});
    wait_done("illegal_next");
    $display("illegal op=6 then wr_addr accepted");

    // Reset during the 3rd data word of an 8-word write
    tick();
    wait_ready("rstmid");
    cmd_op_i = 3'd3; cmd_len_i = 13'd8; cmd_fpga_i = 4'd2; cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    g = 0; low = 0;
    while (low < 3 && g < 40) begin
      if (fp1_dv_o && ctrl_trce_o && fp1_data_o != 16'h0008) low++;
      if (low < 3) begin
        wr_data_valid_i = wr_data_ready_o;
        wr_data_i = 16'hB000 + 16'(g);
        tick();
        g++;
      end
    end
    wr_data_valid_i = 1'b0;
    check("rstmid_reached_word3", low, 3);
    #2 rst = 1'b0;
    #1;
    check("rstmid_async_drop", {ctrl_trce_o, fp1_dv_o, carte_o, cmd_ready_o}, 4'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rstmid_ready", cmd_ready_o, 1);
    found = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_o || ctrl_trce_o) found = 1;
      tick();
    end
    check("rstmid_no_done", found, 0);
    $display("reset mid-frame recovered");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1);
  end

endmodule
